// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-register sequencer.
package shift_seq_pkg;

    localparam int SHIFT_N_DEFAULT = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_shift_reg.sv
// N-bit bidirectional shift register with parallel load and serial-out mux.
module shift_reg_n
    import shift_seq_pkg::*;
#(
    parameter int N = SHIFT_N_DEFAULT
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         load,
    input  logic         shift_en,
    input  logic         dir,
    input  logic         sin,
    input  logic [N-1:0] din,
    output logic [N-1:0] q,
    output logic [N-1:0] shifted,
    output logic         sout
);

    // A single-bit register simply takes the serial input on a shift.
    generate
        if (N == 1) begin : g_one
            assign shifted = sin;
        end else begin : g_wide
            assign shifted = dir ? {sin, q[N-1:1]} : {q[N-2:0], sin};
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift_en) begin
            q <= shifted;
        end
    end

    assign sout = dir ? q[0] : q[N-1];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer: load on Start, N shifts, snapshot and one-cycle Done pulse.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int N  = SHIFT_N_DEFAULT,
    parameter int CW = $clog2(N)
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Start,
    input  logic         Dir,
    input  logic [N-1:0] Din,
    input  logic         Sin,
    output logic [N-1:0] Q,
    output logic         Sout,
    output logic [N-1:0] Snap,
    output logic         Busy,
    output logic         Done,
    output state_t       DbgState
);

    // Start is a request taken only while Busy is low; there is no backpressure,
    // so a request raised while Busy is high is dropped rather than queued.

    // CW collapses to 0 when N == 1, so the counter keeps at least one bit.
    localparam int              CNT_W = (CW < 1) ? 1 : CW;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] count;
    logic             dir_q;
    logic             load, shift_en, last_shift;
    logic [N-1:0]     shifted;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    load       = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (count == LAST) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign last_shift = shift_en && (count == LAST);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= S_IDLE;
            count <= '0;
            dir_q <= 1'b0;
            Snap  <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_next;
            Busy  <= (state_next != S_IDLE);
            Done  <= (state_next == S_DONE);
            if (load) begin
                dir_q <= Dir;
                count <= '0;
            end else if (shift_en && !last_shift) begin
                count <= count + 1'b1;
            end
            if (last_shift) Snap <= shifted;
        end
    end

    shift_reg_n #(.N(N)) u_reg (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .load     (load),
        .shift_en (shift_en),
        .dir      (dir_q),
        .sin      (Sin),
        .din      (Din),
        .q        (Q),
        .shifted  (shifted),
        .sout     (Sout)
    );

    assign DbgState = state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: N=10 and N=1 instances, queue-based model.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int N = 10;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic         Resetn;
  logic         Start, Dir, Sin;
  logic [N-1:0] Din;
  logic [N-1:0] Q, Snap;
  logic         Sout, Busy, Done;
  state_t       dbg;

  logic         s1_start, s1_dir, s1_sin;
  logic [0:0]   s1_din, s1_q, s1_snap;
  logic         s1_sout, s1_busy, s1_done;
  state_t       s1_dbg;

  int cyc = 0;
  int acc_cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  shift_seq_ctrl #(.N(N)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Dir(Dir), .Din(Din), .Sin(Sin),
    .Q(Q), .Sout(Sout), .Snap(Snap), .Busy(Busy), .Done(Done), .DbgState(dbg)
  );

  shift_seq_ctrl #(.N(1)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .Start(s1_start), .Dir(s1_dir), .Din(s1_din), .Sin(s1_sin),
    .Q(s1_q), .Sout(s1_sout), .Snap(s1_snap), .Busy(s1_busy), .Done(s1_done), .DbgState(s1_dbg)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [N-1:0] din, input logic dir);
    Start = 1'b1;
    Din   = din;
    Dir   = dir;
    @(posedge Clock); #1;
    acc_cyc = cyc;
    @(negedge Clock);
    chk("acc_busy", Busy, 1);
    chk("acc_done", Done, 0);
    chk("acc_q", Q, din);
    chk("acc_state", dbg, S_SHIFT);
  endtask

  // sin_mode: 0 random, 1 loopback from Sout, 2 constant 0, 3 constant 1
  task automatic shift_phase(input logic [N-1:0] din, input logic dir, input int sin_mode, input bit hold);
    logic         exp_q[$];
    logic         sin_bits[$];
    logic [N-1:0] exp_snap;
    // Serial output stream is the loaded word, MSB-first or LSB-first.
    for (int i = 0; i < N; i++) exp_q.push_back(dir ? din[i] : din[N-1-i]);
    for (int k = 0; k < N; k++) begin
      chk("sout", Sout, exp_q.pop_front());
      chk("busy_shift", Busy, 1);
      chk("done_shift", Done, 0);
      Start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      Din   = N'($urandom);
      Dir   = 1'($urandom_range(0, 1));
      case (sin_mode)
        0:       Sin = 1'($urandom_range(0, 1));
        1:       Sin = Sout;
        2:       Sin = 1'b0;
        default: Sin = 1'b1;
      endcase
      sin_bits.push_back(Sin);
      @(posedge Clock); #1;
    end
    // After N shifts the register holds exactly the serial input stream.
    for (int j = 0; j < N; j++) begin
      if (dir) exp_snap[j] = sin_bits[j];
      else     exp_snap[N-1-j] = sin_bits[j];
    end
    Start = hold;
    chk("done_pulse", Done, 1);
    chk("done_busy", Busy, 1);
    chk("done_snap", Snap, exp_snap);
    chk("done_q", Q, exp_snap);
    chk("done_state", dbg, S_DONE);
    if (sin_mode == 1) chk("loop_snap", Snap, din);
    @(posedge Clock); #1;
    chk("idle_done", Done, 0);
    chk("idle_busy", Busy, 0);
    chk("idle_q", Q, exp_snap);
    chk("idle_snap", Snap, exp_snap);
  endtask

  task automatic full_txn(input logic [N-1:0] din, input logic dir, input int sin_mode, input bit hold);
    accept(din, dir);
    shift_phase(din, dir, sin_mode, hold);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int prev_acc;
    logic [N-1:0] d;
    logic b_din, b_dir, b_sin;

    Resetn = 1'b0; Start = 1'b0; Dir = 1'b0; Sin = 1'b0; Din = '0;
    s1_start = 1'b0; s1_dir = 1'b0; s1_sin = 1'b0; s1_din = '0;
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;
    @(negedge Clock);
    chk("rst_q", Q, 0);
    chk("rst_snap", Snap, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_sout", Sout, 0);
    chk("rst_state", dbg, S_IDLE);
    chk("rst1_q", s1_q, 0);
    chk("rst1_busy", s1_busy, 0);

    // Directed cases from the test plan
    full_txn(10'b0001110111, 1'b0, 2, 1'b0);
    chk("left_snap0", Snap, 10'h000);
    full_txn(10'b0001110111, 1'b1, 3, 1'b0);
    chk("right_fill", Snap, 10'h3FF);
    full_txn(10'h2A5, 1'b0, 1, 1'b0);

    // Start held high: back-to-back acceptance every N+2 cycles
    full_txn(N'($urandom), 1'($urandom_range(0, 1)), 0, 1'b1);
    for (int t = 0; t < 3; t++) begin
      prev_acc = acc_cyc;
      full_txn(N'($urandom), 1'($urandom_range(0, 1)), 0, 1'b1);
      chk("b2b_gap", 32'(acc_cyc - prev_acc), N + 2);
    end
    Start = 1'b0;

    // Reset during SHIFT at the 5th shift edge, with Start asserted
    accept(10'h1C3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      Start = 1'b0;
      Sin = 1'($urandom_range(0, 1));
      @(posedge Clock); #1;
    end
    Resetn = 1'b0;
    Start  = 1'b1;
    @(posedge Clock); #1;
    Resetn = 1'b1;
    d = N'($urandom);
    Din = d;
    Dir = 1'b1;
    @(negedge Clock);
    chk("abort_q", Q, 0);
    chk("abort_snap", Snap, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_state", dbg, S_IDLE);
    @(posedge Clock); #1;
    @(negedge Clock);
    chk("reacc_busy", Busy, 1);
    chk("reacc_q", Q, d);
    shift_phase(d, 1'b1, 0, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 6; t++) begin
      full_txn(N'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 1), 1'b0);
    end
    Start = 1'b0;

    // N=1 instance: directed case then random
    for (int t = 0; t < 5; t++) begin
      b_din = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      b_dir = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      b_sin = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      s1_start = 1'b1; s1_din = b_din; s1_dir = b_dir;
      @(posedge Clock); #1;
      s1_start = 1'b1; s1_din = ~b_din; s1_dir = ~b_dir; s1_sin = b_sin;
      chk("n1_sout", s1_sout, b_din);
      chk("n1_busy", s1_busy, 1);
      chk("n1_done0", s1_done, 0);
      @(posedge Clock); #1;
      s1_start = 1'b0;
      chk("n1_done", s1_done, 1);
      chk("n1_snap", s1_snap, b_sin);
      chk("n1_q", s1_q, b_sin);
      @(posedge Clock); #1;
      chk("n1_idle_done", s1_done, 0);
      chk("n1_idle_busy", s1_busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer for an N-bit bidirectional shift register. On a start request it parallel-loads a word, runs exactly N shift cycles while streaming bits out serially and in from a serial input, captures the final register contents into a snapshot output, and pulses a completion flag. It sits between a requester issuing start/data and the serial link that the shift datapath drives.

## Interface
Parameters:
- N, default 10: register width in bits; legal range N >= 1.
- CW, default $clog2(N): shift-counter width. Derived; do not override.

Ports:
- Clock  in  1  sole clock; all state changes on posedge.
- Resetn  in  1  reset, synchronous and active-low, sampled on posedge Clock.
- Start  in  1  transaction request; sampled only in IDLE.
- Dir  in  1  shift direction, latched with Start. 0 = toward MSB (Sin→Q[0]); 1 = toward LSB (Sin→Q[N-1]).
- Din  in  N  parallel load word, sampled with Start.
- Sin  in  1  serial input, sampled on every shift edge.
- Q  out  N  live register contents.
- Sout  out  1  serial output. Q[N-1] when latched Dir=0; Q[0] when latched Dir=1. Combinational from Q and latched Dir.
- Snap  out  N  register value captured at the last shift; held until the next completion.
- Busy  out  1  high in SHIFT and DONE.
- Done  out  1  one-cycle completion pulse.

## Operation
- Reset (Resetn=0 at an edge) clears state to IDLE, Q=0, Snap=0, latched Dir=0, count=0, Busy=0 and Done=0. Sout is therefore 0. Reset has priority over every other event.
- IDLE: if Start=1 at the edge, then Q<=Din, Dir is latched, count<=0 and the next state is SHIFT. Otherwise everything holds.
- SHIFT: each edge performs one shift.
  - Dir=0: Q<={Q[N-2:0],Sin}.
  - Dir=1: Q<={Sin,Q[N-1:1]}.
  - The count increments on each shift.
  - On the edge where count==N-1: perform the final shift, set Snap to the post-shift value, and go to DONE.
- DONE: Done=1 and Q holds. The next edge always returns to IDLE.
- Start in SHIFT or DONE is ignored and not queued. Din, Dir and Sin changes outside their sampling edges have no effect.
- N=1: exactly one shift edge, then DONE.
- Reset in SHIFT or DONE aborts the transaction. No Done pulse is produced and Snap is cleared.
- Start held high continuously yields back-to-back transactions, one accepted every N+2 cycles.

## Timing
- Let edge e0 be the edge that accepts Start.
  - Load occurs at e0.
  - Shifts occur at e0+1 … e0+N.
  - Snap updates at e0+N.
  - Done=1 in the cycle after e0+N.
  - IDLE is re-entered at e0+N+1.
- The bit on Sout during the cycle before shift edge e0+k is the k-th serial bit out (k=1..N). The first bit is visible immediately after e0.
- Busy rises after e0 and falls after e0+N+1.
- All outputs are registered except Sout, which is one combinational mux on registered signals.

## Structure
- Package shift_seq_pkg holds:
  - typedef enum state_t {S_IDLE, S_SHIFT, S_DONE};
  - the default width constant (10).
- Sub-module shift_reg_n (parameter N) holds the datapath: an N-bit register with load, shift-enable, dir and sin inputs and q output, plus the Sout mux.
- shift_seq_ctrl holds the FSM, the counter, the Dir latch and Snap.

## Test plan
- Left shift: N=10, Din=10'b0001110111, Dir=0, Sin=0 → Sout MSB-first 0,0,0,1,1,1,0,1,1,1; Snap=0; Done exactly one cycle, 11 cycles after e0.
- Right fill: Din=10'b0001110111, Dir=1, Sin=1 → Sout LSB-first 1,1,1,0,1,1,1,0,0,0; Snap=10'h3FF.
- Loopback: Sin tied to Sout, Dir=0, Din=10'h2A5 → Snap=10'h2A5 (full rotation); Q=10'h2A5 during DONE.
- Start held high for 40 cycles → accepts at cycles 0, 12, 24, 36; Done pulses 11 cycles after each; pulses while Busy ignored.
- Reset mid-op: Resetn=0 at the 5th shift edge → next cycle Q=0, Snap=0, Busy=0; no Done; a fresh Start is accepted on the following edge.
- N=1 instance: Din=1, Dir=0, Sin=0 → Sout=1 before the single shift; Snap=0; Done two cycles after e0.
